// File: rtl/spike_decoder_pkg.sv
// Shared types and Q16.16 constants for the spike-rate/velocity decoder.
package spike_decoder_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCALE  = 3'd1,
    FILTER = 3'd2,
    DIFF   = 3'd3,
    OUT    = 3'd4
  } state_e;

  localparam logic [31:0] Q_ONE   = 32'h0001_0000;
  localparam logic [31:0] S32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] S32_MIN = 32'h8000_0000;

endpackage

// File: rtl/sat_s33_to_s32.sv
// Combinational saturator: clamps a signed 33-bit value into the signed 32-bit range.
module sat_s33_to_s32
  import spike_decoder_pkg::*;
(
  input  logic [32:0] i_val,
  output logic [31:0] o_sat
);

  always_comb begin
    o_sat = i_val[31:0];
    // The two top bits disagree exactly when the value does not fit in 32 bits.
    if (i_val[32] != i_val[31]) o_sat = i_val[32] ? S32_MIN : S32_MAX;
  end

endmodule

// File: rtl/spike_rate_velocity_decoder.sv
// Spike count -> EMA-smoothed Q16.16 rate and per-window velocity, one sample per 4-stage pass.
// Optional feature macro: VEL_DEADBAND_EN (zeroes |vel| below DEADBAND).
module spike_rate_velocity_decoder
  import spike_decoder_pkg::*;
#(
  parameter logic [15:0] CNT_CLAMP = 16'hFFFF,
  parameter logic [31:0] DEADBAND  = 32'h0000_8000
) (
  input  logic        sim_clk,
  input  logic        reset_sim,
  input  logic [31:0] cnt_in,
  input  logic        cnt_valid,
  input  logic [15:0] gain,
  input  logic [3:0]  tau_shift,
  output logic [31:0] rate_out,
  output logic [31:0] vel_out,
  output logic        out_valid,
  output logic        busy,
  output logic        dropped
);

`ifdef VEL_DEADBAND_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  state_e      r_state, w_next;
  logic [31:0] r_cnt, r_pend_cnt, r_x, r_rate, r_rate_prev, r_rate_out, r_vel_out;
  logic        r_pend_full, r_primed, r_dropped;
  logic        w_issue, w_take_pend, w_load_pend, w_drop;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge sim_clk or posedge reset_sim) begin
    if (reset_sim) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next      = r_state;
    w_issue     = 1'b0;
    w_take_pend = 1'b0;
    w_load_pend = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      // OUT is the return-to-idle cycle: a waiting sample starts at once, and a
      // fresh strobe in the same cycle refills the slot that was just freed.
      IDLE, OUT: begin
        if (r_pend_full) begin
          w_issue     = 1'b1;
          w_take_pend = 1'b1;
          w_load_pend = cnt_valid;
        end else if (cnt_valid) begin
          w_issue = 1'b1;
        end
        w_next = w_issue ? SCALE : IDLE;
      end
      SCALE:   w_next = FILTER;
      FILTER:  w_next = DIFF;
      DIFF:    w_next = OUT;
      default: w_next = IDLE;
    endcase
    if (cnt_valid && (r_state inside {SCALE, FILTER, DIFF})) begin
      if (r_pend_full) w_drop = 1'b1;
      else             w_load_pend = 1'b1;
    end
  end

  logic [15:0] w_clamped;
  logic [31:0] w_prod, w_x_sat, w_rate_sat, w_vel_sat, w_vel;
  logic [39:0] w_x_wide;
  logic [32:0] w_err, w_step, w_rate_sum, w_vel_diff;
  logic        w_in_band;

  assign w_clamped  = (r_cnt > {16'd0, CNT_CLAMP}) ? CNT_CLAMP : r_cnt[15:0];
  assign w_prod     = {16'd0, w_clamped} * {16'd0, gain};
  assign w_x_wide   = {w_prod, 8'h00};
  assign w_x_sat    = (w_x_wide > {8'd0, S32_MAX}) ? S32_MAX : w_x_wide[31:0];

  assign w_err      = $signed({r_x[31], r_x}) - $signed({r_rate[31], r_rate});
  assign w_step     = $signed(w_err) >>> tau_shift;
  assign w_rate_sum = $signed({r_rate[31], r_rate}) + $signed(w_step);
  assign w_vel_diff = $signed({r_rate[31], r_rate}) - $signed({r_rate_prev[31], r_rate_prev});

  sat_s33_to_s32 u_sat_rate (.i_val(w_rate_sum), .o_sat(w_rate_sat));
  sat_s33_to_s32 u_sat_vel  (.i_val(w_vel_diff), .o_sat(w_vel_sat));

  assign w_in_band = DB_EN && ($signed(w_vel_sat) > -$signed(DEADBAND))
                           && ($signed(w_vel_sat) <  $signed(DEADBAND));
  assign w_vel     = (!r_primed || w_in_band) ? 32'd0 : w_vel_sat;

  always_ff @(posedge sim_clk or posedge reset_sim) begin
    if (reset_sim) begin
      r_cnt       <= '0;
      r_pend_cnt  <= '0;
      r_pend_full <= 1'b0;
      r_dropped   <= 1'b0;
      r_x         <= '0;
      r_rate      <= '0;
      r_rate_prev <= '0;
      r_primed    <= 1'b0;
      r_rate_out  <= '0;
      r_vel_out   <= '0;
    end else begin
      if (w_issue) r_cnt <= w_take_pend ? r_pend_cnt : cnt_in;
      if (w_load_pend) begin
        r_pend_full <= 1'b1;
        r_pend_cnt  <= cnt_in;
      end else if (w_take_pend) begin
        r_pend_full <= 1'b0;
      end
      if (w_drop) r_dropped <= 1'b1;
      case (r_state)
        SCALE:  r_x    <= w_x_sat;
        FILTER: r_rate <= w_rate_sat;
        // Results are loaded on entry to OUT so they are stable while out_valid is high.
        DIFF: begin
          r_rate_out  <= r_rate;
          r_vel_out   <= w_vel;
          r_rate_prev <= r_rate;
          r_primed    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rate_out  = r_rate_out;
  assign vel_out   = r_vel_out;
  assign out_valid = (r_state == OUT);
  assign busy      = (r_state != IDLE);
  assign dropped   = r_dropped;

endmodule

// File: tb/tb_spike_rate_velocity_decoder.sv
// Scoreboard bench: a job-level reference model queues expected outputs; a monitor checks each out_valid.
module tb_spike_rate_velocity_decoder;
  import spike_decoder_pkg::*;

  logic        sim_clk = 1'b0;
  logic        reset_sim = 1'b0;
  logic [31:0] cnt_in = '0;
  logic        cnt_valid = 1'b0;
  logic [15:0] gain = 16'h0100;
  logic [3:0]  tau_shift = '0;
  logic [31:0] rate_out, vel_out;
  logic        out_valid, busy, dropped;

  spike_rate_velocity_decoder dut (
    .sim_clk(sim_clk), .reset_sim(reset_sim), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
    .gain(gain), .tau_shift(tau_shift), .rate_out(rate_out), .vel_out(vel_out),
    .out_valid(out_valid), .busy(busy), .dropped(dropped)
  );

  always #5 sim_clk = ~sim_clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] rate;
    logic [31:0] vel;
  } exp_t;

  localparam longint L_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint L_MIN = -64'sh0000_0000_8000_0000;

  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, job_end = -100, n_out = 0, last_out_cyc = 0, prev_out_cyc = 0;
  bit          pend = 1'b0, drop_exp = 1'b0, m_primed = 1'b0;
  logic [31:0] pend_val = '0, last_rate = '0, last_vel = '0;
  longint      m_rate = 0, m_prev = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic longint sat32(input longint v);
    if (v > L_MAX) return L_MAX;
    if (v < L_MIN) return L_MIN;
    return v;
  endfunction

  // One sample through the decoder, in plain arithmetic.
  task automatic model_start(input logic [31:0] c);
    longint cc, x, rn, v;
    cc = (c > 32'h0000_FFFF) ? 65535 : longint'(c);
    x  = cc * longint'(gain) * 256;
    if (x > L_MAX) x = L_MAX;
    rn = sat32(m_rate + ((x - m_rate) >>> tau_shift));
    v  = m_primed ? sat32(rn - m_prev) : 0;
`ifdef VEL_DEADBAND_EN
    if (v > -32768 && v < 32768) v = 0;
`endif
    m_primed = 1'b1;
    m_prev   = rn;
    m_rate   = rn;
    exp_q.push_back('{rate: rn[31:0], vel: v[31:0]});
  endtask

  // Occupancy: a job accepted in cycle c reports in cycle c+4 and can hand over
  // to the waiting sample in that same cycle; one sample may wait.
  task automatic model_cycle(input bit v, input logic [31:0] c);
    if (cyc > job_end) begin
      if (v) begin model_start(c); job_end = cyc + 4; end
    end else if (cyc == job_end) begin
      if (pend) begin
        model_start(pend_val);
        job_end  = cyc + 4;
        pend     = v;
        pend_val = c;
      end else if (v) begin
        model_start(c);
        job_end = cyc + 4;
      end
    end else if (v) begin
      if (pend) drop_exp = 1'b1;
      else begin pend = 1'b1; pend_val = c; end
    end
  endtask

  task automatic step(input bit v, input logic [31:0] c);
    cnt_valid = v;
    cnt_in    = c;
    model_cycle(v, c);
    @(posedge sim_clk);
    #1;
    cyc++;
    cnt_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step(1'b0, '0);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    step(1'b0, '0);
    step(1'b0, '0);
  endtask

  task automatic do_reset();
    cnt_valid = 1'b0;
    reset_sim = 1'b1;
    #1;
    check("rst_rate_out", rate_out, 0);
    check("rst_vel_out", vel_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped, 0);
    repeat (2) @(posedge sim_clk);
    #1;
    reset_sim = 1'b0;
    exp_q.delete();
    m_rate = 0; m_prev = 0; m_primed = 1'b0;
    pend = 1'b0; drop_exp = 1'b0; job_end = cyc - 100;
  endtask

  always @(negedge sim_clk) begin
    if (!reset_sim && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_rate", rate_out, mon_e.rate);
        check("sb_vel", vel_out, mon_e.vel);
      end
      last_rate    = rate_out;
      last_vel     = vel_out;
      prev_out_cyc = last_out_cyc;
      last_out_cyc = cyc;
      n_out++;
    end
  end

  initial begin
    int          c0, n0;
    logic [31:0] exp3[3];
    exp3 = '{32'h0004_0000, 32'h0006_0000, 32'h0007_0000};

    do_reset();

    // First sample after reset: unity gain, no smoothing, no velocity step.
    gain = 16'h0100; tau_shift = 4'd0;
    c0 = cyc;
    step(1'b1, 32'd10);
    drain();
    check("t1_rate", last_rate, 32'h000A_0000);
    check("t1_vel", last_vel, 32'h0);
    check("t1_latency", 64'(last_out_cyc - c0), 64'd4);

    step(1'b1, 32'd14);
    drain();
    check("t2_rate", last_rate, 32'h000E_0000);
    check("t2_vel", last_vel, 32'h0004_0000);

    // EMA with k=1 converging towards 8.0.
    do_reset();
    tau_shift = 4'd1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'd8);
      drain();
      check("t3_rate", last_rate, exp3[i]);
    end
    repeat (17) begin
      step(1'b1, 32'd8);
      drain();
    end
    check("t3_converged", 64'(last_rate >= 32'h0007_FF00 && last_rate <= 32'h0008_0000), 64'd1);

    // Oversized count with maximum gain saturates, never wraps negative.
    tau_shift = 4'd0; gain = 16'hFFFF;
    step(1'b1, 32'h0010_0000);
    drain();
    check("t4_rate_sat", last_rate, S32_MAX);

    // Back-to-back strobes: second waits in the slot, third is lost.
    do_reset();
    gain = 16'h0100; tau_shift = 4'd0;
    n0 = n_out;
    step(1'b1, 32'd3);
    check("t5_busy", busy, 1);
    step(1'b1, 32'd5);
    step(1'b1, 32'd7);
    check("t5_dropped", dropped, 1);
    drain();
    check("t5_outputs", 64'(n_out - n0), 64'd2);
    check("t5_spacing", 64'(last_out_cyc - prev_out_cyc), 64'd4);
    check("t5_rate", last_rate, 32'h0005_0000);
    check("t5_vel", last_vel, 32'h0002_0000);

    // Reset while a sample is in FILTER discards it and clears the filter state.
    do_reset();
    step(1'b1, 32'd9);
    drain();
    step(1'b1, 32'd12);
    step(1'b0, '0);
    check("t6_busy_before_reset", busy, 1);
    do_reset();
    n0 = n_out;
    repeat (10) step(1'b0, '0);
    check("t6_no_out_after_reset", 64'(n_out - n0), 64'd0);
    tau_shift = 4'd2;
    step(1'b1, 32'd2);
    drain();
    check("t6_rate_fresh", last_rate, 32'h0000_8000);
    check("t6_vel_fresh", last_vel, 32'h0);

    // Small rate step of 0.25: hidden by the deadband when it is enabled.
    tau_shift = 4'd0; gain = 16'h0100;
    step(1'b1, 32'd1);
    drain();
    check("t6_rate_one", last_rate, Q_ONE);
    gain = 16'h0140;
    step(1'b1, 32'd1);
    drain();
    check("t6_rate_step", last_rate, 32'h0001_4000);
`ifdef VEL_DEADBAND_EN
    check("t6_vel_deadband", last_vel, 32'h0);
`else
    check("t6_vel_raw", last_vel, 32'h0000_4000);
`endif

    // Randomized bursts against the reference model.
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      gain      = 16'($urandom_range(0, 16'hFFFF));
      tau_shift = 4'($urandom_range(0, 6));
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 7) == 0) step($urandom_range(0, 2) == 0, $urandom);
        else                           step($urandom_range(0, 2) == 0, 32'($urandom_range(0, 300)));
      end
      drain();
      check("rand_dropped", dropped, drop_exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
